// File: rtl/aes_pkg.sv
// Shared types and helpers for the iterative AES key schedule.
// Nk/Nr are derived from the key length; xtime is the GF(2^8) doubling used for rcon.
package aes_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  function automatic int nk_of(input int k);
    return k / 32;
  endfunction

  function automatic int nr_of(input int k);
    return k / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational byte substitution.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  always_comb begin
    s = 8'h00;
    case (a)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key expansion: one 32-bit schedule word per clk, round keys
// {w[4r]..w[4r+3]} handed to the cipher datapath over a valid/ready port.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int K = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [K-1:0] key,
  output logic [127:0] round_key,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  localparam int NK = nk_of(K);
  localparam int NR = nr_of(K);
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK6   = 6'(NK);
  localparam logic [5:0] NW6   = 6'(NW);
  localparam logic [2:0] NK_M1 = 3'(NK - 1);
  localparam logic [3:0] NR4   = 4'(NR);

  state_t        state, state_nxt;
  logic [5:0]    wi;
  logic [2:0]    wmod;
  logic [7:0]    rcon;
  logic [K-1:0]  window;
  logic [95:0]   collect;
  logic [3:0]    rnd;

  logic [31:0]   w_msb, w_lsb, sbox_in, sub_out, t_word, new_word;
  logic          hs, stall, step, last_hs;

  // Handshake: round_key/rk_idx transfer on any edge where rk_valid && rk_ready;
  // while rk_valid && !rk_ready the outputs are frozen and no word step occurs.
  assign hs      = rk_valid && rk_ready;
  assign stall   = rk_valid && !rk_ready;
  assign step    = (state == EXPAND) && !stall && (wi != NW6);
  assign last_hs = hs && (rk_idx == NR4);
  assign busy    = (state == EXPAND);

  // Window holds w[i-Nk] in its top word and w[i-1] in its bottom word.
  assign w_msb   = window[K-1 -: 32];
  assign w_lsb   = window[31:0];
  assign sbox_in = (wmod == 3'd0) ? {w_lsb[23:0], w_lsb[31:24]} : w_lsb;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sbox_in[8*b +: 8]),
      .s (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    t_word   = w_lsb;
    new_word = w_msb;
    if (wi >= NK6) begin
      if (wmod == 3'd0) begin
        t_word = sub_out ^ {rcon, 24'h0};
      end else if (NK == 8 && wmod == 3'd4) begin
        t_word = sub_out;
      end
      new_word = w_msb ^ t_word;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = EXPAND;
      EXPAND:  if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wi        <= 6'd0;
      wmod      <= 3'd0;
      rcon      <= 8'h01;
      window    <= '0;
      collect   <= '0;
      rnd       <= 4'd0;
      round_key <= '0;
      rk_idx    <= 4'd0;
      rk_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= last_hs;
      if (state == IDLE) begin
        if (start) begin
          window <= key;
          wi     <= 6'd0;
          wmod   <= 3'd0;
          rcon   <= 8'h01;
          rnd    <= 4'd0;
        end
      end else begin
        if (hs) rk_valid <= 1'b0;
        if (step) begin
          window <= {window[K-33:0], new_word};
          wi     <= wi + 6'd1;
          wmod   <= (wmod == NK_M1) ? 3'd0 : wmod + 3'd1;
          if (wi >= NK6 && wmod == 3'd0) rcon <= xtime(rcon);
          case (wi[1:0])
            2'd0: collect[95:64] <= new_word;
            2'd1: collect[63:32] <= new_word;
            2'd2: collect[31:0]  <= new_word;
            default: begin
              // Slot 3 completes a round key; this overrides the drop from a same-edge handshake.
              round_key <= {collect, new_word};
              rk_idx    <= rnd;
              rk_valid  <= 1'b1;
              rnd       <= rnd + 4'd1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors, random keys under backpressure,
// start-while-busy, restart in the done cycle and asynchronous reset mid-run.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         start128 = 1'b0, rdy128 = 1'b0;
  logic [127:0] key128 = '0;
  logic [127:0] rk128;
  logic [3:0]   idx128;
  logic         v128, busy128, done128;

  logic         start192 = 1'b0, rdy192 = 1'b0;
  logic [191:0] key192 = '0;
  logic [127:0] rk192;
  logic [3:0]   idx192;
  logic         v192, busy192, done192;

  logic         start256 = 1'b0, rdy256 = 1'b0;
  logic [255:0] key256 = '0;
  logic [127:0] rk256;
  logic [3:0]   idx256;
  logic         v256, busy256, done256;

  int n_cmp = 0;
  int n_bad = 0;

  logic [131:0] exp_q[$];
  logic [131:0] got128[$], got192[$], got256[$];
  int           dn192 = 0, dn256 = 0;
  logic [7:0]   sbox_ref[256];

  always #5 clk = ~clk;

  aes_key_expand #(.K(128)) u_d128 (
    .clk(clk), .rst_n(rst_n), .start(start128), .key(key128), .round_key(rk128),
    .rk_idx(idx128), .rk_valid(v128), .rk_ready(rdy128), .busy(busy128), .done(done128));
  aes_key_expand #(.K(192)) u_d192 (
    .clk(clk), .rst_n(rst_n), .start(start192), .key(key192), .round_key(rk192),
    .rk_idx(idx192), .rk_valid(v192), .rk_ready(rdy192), .busy(busy192), .done(done192));
  aes_key_expand #(.K(256)) u_d256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .key(key256), .round_key(rk256),
    .rk_idx(idx256), .rk_valid(v256), .rk_ready(rdy256), .busy(busy256), .done(done256));

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  // Key is left-aligned in kin; fills exp_q with {idx, round_key} for rounds 0..Nr.
  task automatic build_exp(input int nk, input logic [255:0] kin);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    exp_q.delete();
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = kin[255 - 32 * i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++)
      exp_q.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  task automatic check_sb(input string tag, input logic [131:0] got[$]);
    chk({tag, "_count"}, 132'(got.size()), 132'(exp_q.size()));
    for (int n = 0; n < exp_q.size(); n++)
      chk(tag, (n < got.size()) ? got[n] : 132'h0, exp_q[n]);
  endtask

  // ---------------- monitors ----------------
  logic         prev_stall = 1'b0;
  logic [127:0] prev_rk = '0;
  logic [3:0]   prev_idx = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {v128, idx128, rk128}, {1'b1, prev_idx, prev_rk});
      if (v128 && rdy128) got128.push_back({idx128, rk128});
      prev_stall = v128 && !rdy128;
      prev_rk    = rk128;
      prev_idx   = idx128;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (v192 && rdy192) got192.push_back({idx192, rk192});
      if (v256 && rdy256) got256.push_back({idx256, rk256});
      if (done192) dn192++;
      if (done256) dn256++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic run128_to_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      tick();
      if (done128) seen = 1'b1;
    end
    chk(tag, 132'(seen), 132'(1'b1));
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] k_a, k_b;
  logic         seen_done;

  initial begin
    build_sbox();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_rk", 132'(rk128), 132'h0);
    chk("rst_idx", 132'(idx128), 132'h0);
    chk("rst_ctl", {v128, busy128, done128, v192, busy192, v256, busy256}, 132'h0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 K=128, consumer always ready
    key128 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    build_exp(4, {key128, 128'h0});
    rdy128 = 1'b1;
    got128.delete();
    start128 = 1'b1;
    tick();                               // E0
    start128 = 1'b0;
    chk("a_busy", 132'(busy128), 132'h1);
    repeat (3) tick();                    // E3
    chk("a_v_e3", 132'(v128), 132'h0);
    tick();                               // E4
    chk("a_r0", {v128, idx128, rk128}, {1'b1, 4'd0, key128});
    repeat (40) tick();                   // E44
    chk("a_r10", {v128, idx128, rk128}, {1'b1, 4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6});
    chk("a_done_e44", 132'(done128), 132'h0);
    tick();                               // E45
    chk("a_done_e45", {done128, busy128, v128}, {1'b1, 1'b0, 1'b0});
    tick();
    chk("a_done_pulse", 132'(done128), 132'h0);
    chk("a_r1_lit", (got128.size() > 1) ? got128[1] : 132'h0, {4'd1, 128'ha0fafe17_88542cb1_23a33939_2a6c7605});
    check_sb("a_sb", got128);

    // Random key, 30% ready, start pulsed mid-run with a different key
    k_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    k_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    key128 = k_a;
    build_exp(4, {k_a, 128'h0});
    got128.delete();
    start128 = 1'b1;
    tick();
    start128 = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 3000 && !seen_done; c++) begin
      rdy128 = ($urandom_range(0, 9) < 3);
      if (c == 20) begin
        start128 = 1'b1;
        key128   = k_b;
      end else begin
        start128 = 1'b0;
      end
      tick();
      if (c == 20) chk("b_busy_mid", 132'(busy128), 132'h1);
      if (done128) seen_done = 1'b1;
    end
    start128 = 1'b0;
    chk("b_done_seen", 132'(seen_done), 132'h1);
    check_sb("b_sb", got128);

    // Restart in the done cycle with key k_b
    build_exp(4, {k_b, 128'h0});
    got128.delete();
    rdy128   = 1'b1;
    start128 = 1'b1;
    tick();
    start128 = 1'b0;
    chk("c_busy_restart", 132'(busy128), 132'h1);
    repeat (4) tick();
    chk("c_r0", {v128, idx128, rk128}, {1'b1, 4'd0, k_b});
    run128_to_done("c_done_seen", 100);
    check_sb("c_sb", got128);

    // FIPS-197 K=192 and K=256 in parallel, always ready
    key192 = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
    key256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    rdy192 = 1'b1; rdy256 = 1'b1;
    got192.delete(); got256.delete();
    start192 = 1'b1; start256 = 1'b1;
    tick();
    start192 = 1'b0; start256 = 1'b0;
    repeat (4) tick();
    chk("d192_r0", {v192, idx192, rk192}, {1'b1, 4'd0, key192[191:64]});
    chk("d256_r0", {v256, idx256, rk256}, {1'b1, 4'd0, key256[255:128]});
    repeat (70) tick();
    chk("d192_done_once", 132'(dn192), 132'd1);
    chk("d256_done_once", 132'(dn256), 132'd1);
    chk("d192_r12_lit", (got192.size() > 12) ? got192[12] : 132'h0, {4'd12, 128'he98ba06f_448c773c_8ecc7204_01002202});
    chk("d256_r14_lit", (got256.size() > 14) ? got256[14] : 132'h0, {4'd14, 128'hfe4890d1_e6188d0b_046df344_706c631e});
    build_exp(6, {key192, 64'h0});
    check_sb("d192_sb", got192);
    build_exp(8, key256);
    check_sb("d256_sb", got256);

    // Random keys for K=192/256 under random backpressure
    key192 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    key256 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    got192.delete(); got256.delete();
    start192 = 1'b1; start256 = 1'b1;
    tick();
    start192 = 1'b0; start256 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rdy192 = ($urandom_range(0, 9) < 3);
      rdy256 = ($urandom_range(0, 9) < 3);
      tick();
    end
    chk("e192_done", 132'(dn192), 132'd2);
    chk("e256_done", 132'(dn256), 132'd2);
    build_exp(6, {key192, 64'h0});
    check_sb("e192_sb", got192);
    build_exp(8, key256);
    check_sb("e256_sb", got256);

    // Async reset while round 5 waits
    key128 = {$urandom(), $urandom(), $urandom(), $urandom()};
    rdy128 = 1'b1;
    start128 = 1'b1;
    tick();
    start128 = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      tick();
      if (v128 && idx128 == 4'd5) begin
        rdy128    = 1'b0;
        seen_done = 1'b1;
      end
    end
    chk("f_reach_r5", 132'(seen_done), 132'h1);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_rst_now", {v128, idx128, rk128, busy128, done128}, 132'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    rdy128 = 1'b1;
    repeat (10) tick();
    chk("f_idle_after", {v128, idx128, rk128, busy128, done128}, 132'h0);
    key128 = {$urandom(), $urandom(), $urandom(), $urandom()};
    build_exp(4, {key128, 128'h0});
    got128.delete();
    start128 = 1'b1;
    tick();
    start128 = 1'b0;
    repeat (4) tick();
    chk("f_r0", {v128, idx128, rk128}, {1'b1, 4'd0, key128});
    run128_to_done("f_done_seen", 100);
    check_sb("f_sb", got128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
